// File: rtl/vie_mem_stage.sv
// vie MIPS memory-access stage: load data wait, extraction and flush discard.
// Build option: VIE_MEM_UNALIGNED_EN enables LWL/LWR merging.
module vie_mem_stage (
  input  logic         clock,
  input  logic         reset,
  input  logic [159:0] esbus_i,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic [126:0] msbus_o,
  input  logic [32:0]  flushbus_i,
  input  logic         data_data_ok,
  input  logic [31:0]  data_rdata,
  output logic [38:0]  msfwd_o
);

  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LWL = 8'h22;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_LHU = 8'h25;
  localparam logic [7:0] OP_LWR = 8'h26;

  logic        es_valid, es_req;
  logic [7:0]  es_op;
  logic        es_ua;
  logic        flush;

  assign es_valid = esbus_i[159];
  assign es_req   = esbus_i[158];
  assign es_op    = esbus_i[124:117];
  assign es_ua    = (es_op == OP_LWL) | (es_op == OP_LWR);
  assign flush    = flushbus_i[32];

  logic        ms_valid_r, req_r, bd_r;
  logic [31:0] baddr_r, pc_r, res_r;
  logic [7:0]  op_r, cp0_r;
  logic [5:0]  exc_r;
  logic [6:0]  dest_r;
  logic        data_got;
  logic [31:0] rdata_r;
  logic [1:0]  discard_cnt;

  logic op_lb, op_lbu, op_lh, op_lhu, op_lw, op_lwl, op_lwr;
  assign op_lb  = op_r == OP_LB;
  assign op_lbu = op_r == OP_LBU;
  assign op_lh  = op_r == OP_LH;
  assign op_lhu = op_r == OP_LHU;
  assign op_lw  = op_r == OP_LW;
  assign op_lwl = op_r == OP_LWL;
  assign op_lwr = op_r == OP_LWR;

  logic wait_op, is_load, cnt_zero, ms_cango;
  logic load_en, latch, leave;
  logic ua_kill, kill, inc, dec;
  logic [5:0] exc_in;
  logic unused;

`ifdef VIE_MEM_UNALIGNED_EN
  logic [31:0] rt_r;
  assign wait_op = op_lb | op_lbu | op_lh | op_lhu | op_lw
                 | op_lwl | op_lwr;
  assign exc_in  = esbus_i[108:103];
  assign ua_kill = 1'b0;
  assign unused  = ^{flushbus_i[31:0], es_ua};
`else
  assign wait_op = op_lb | op_lbu | op_lh | op_lhu | op_lw;
  // unaligned loads are reserved here; their issued request still returns
  assign exc_in  = esbus_i[108:103] | {5'b0, es_ua};
  assign ua_kill = latch & es_req & es_ua;
  assign unused  = ^{flushbus_i[31:0], esbus_i[31:0], op_lwl, op_lwr};
`endif

  assign is_load    = wait_op & req_r;
  assign cnt_zero   = discard_cnt == 2'd0;
  assign ms_cango   = !is_load | data_got | (data_data_ok & cnt_zero);
  assign ms_allowin = !ms_valid_r | (ms_cango & ws_allowin);
  assign load_en    = ms_allowin & !flush;
  assign latch      = load_en & es_valid;
  assign leave      = ms_valid_r & ms_cango & ws_allowin;

  assign kill = flush & ms_valid_r & is_load & !data_got
              & !(data_data_ok & cnt_zero);
  assign inc  = kill | ua_kill;
  assign dec  = data_data_ok & !cnt_zero;

  logic [31:0] ld_data, res_fin;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign ld_data = data_got ? rdata_r : data_rdata;
  assign bsel    = ld_data[{res_r[1:0], 3'b000} +: 8];
  assign hsel    = res_r[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    res_fin = res_r;
    unique case (1'b1)
      op_lb:  res_fin = {{24{bsel[7]}}, bsel};
      op_lbu: res_fin = {24'b0, bsel};
      op_lh:  res_fin = {{16{hsel[15]}}, hsel};
      op_lhu: res_fin = {16'b0, hsel};
      op_lw:  res_fin = ld_data;
`ifdef VIE_MEM_UNALIGNED_EN
      op_lwl: begin
        unique case (res_r[1:0])
          2'd0: res_fin = {ld_data[7:0], rt_r[23:0]};
          2'd1: res_fin = {ld_data[15:0], rt_r[15:0]};
          2'd2: res_fin = {ld_data[23:0], rt_r[7:0]};
          2'd3: res_fin = ld_data;
        endcase
      end
      op_lwr: begin
        unique case (res_r[1:0])
          2'd0: res_fin = ld_data;
          2'd1: res_fin = {rt_r[31:24], ld_data[31:8]};
          2'd2: res_fin = {rt_r[31:16], ld_data[31:16]};
          2'd3: res_fin = {rt_r[31:8], ld_data[31:24]};
        endcase
      end
`endif
      default: res_fin = res_r;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_valid_r <= 1'b0;
      req_r      <= 1'b0;
      baddr_r    <= '0;
      bd_r       <= 1'b0;
      op_r       <= '0;
      cp0_r      <= '0;
      exc_r      <= '0;
      dest_r     <= '0;
      pc_r       <= '0;
      res_r      <= '0;
    end else begin
      if (flush)
        ms_valid_r <= 1'b0;
      else if (ms_allowin)
        ms_valid_r <= es_valid;
      if (latch) begin
        req_r   <= es_req;
        baddr_r <= esbus_i[157:126];
        bd_r    <= esbus_i[125];
        op_r    <= es_op;
        cp0_r   <= esbus_i[116:109];
        exc_r   <= exc_in;
        dest_r  <= esbus_i[102:96];
        pc_r    <= esbus_i[95:64];
        res_r   <= esbus_i[63:32];
      end
    end
  end

`ifdef VIE_MEM_UNALIGNED_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rt_r <= '0;
    else if (latch)
      rt_r <= esbus_i[31:0];
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_got    <= 1'b0;
      rdata_r     <= '0;
      discard_cnt <= 2'd0;
    end else begin
      if (flush | leave) begin
        data_got <= 1'b0;
      end else if (data_data_ok & ms_valid_r & is_load
                   & cnt_zero & !data_got) begin
        data_got <= 1'b1;
        rdata_r  <= data_rdata;
      end
      if (inc & !dec) begin
        if (discard_cnt != 2'd3)
          discard_cnt <= discard_cnt + 2'd1;
      end else if (dec & !inc) begin
        discard_cnt <= discard_cnt - 2'd1;
      end
    end
  end

  logic we;
  assign we = ms_valid_r & (dest_r[6:5] == 2'b00);

  assign msbus_o = {ms_valid_r & ms_cango & !flush, baddr_r, bd_r,
                    op_r, cp0_r, exc_r, dest_r, pc_r, res_fin};
  assign msfwd_o = {we & !ms_cango, we, dest_r[4:0], res_fin};

endmodule

// File: tb/tb_vie_mem_stage.sv
// Directed scoreboard bench for vie_mem_stage.
// Honours VIE_MEM_UNALIGNED_EN for the LWL case.
module tb_vie_mem_stage;

  localparam logic [7:0] OP_ADDU = 8'h01;
  localparam logic [7:0] OP_LB   = 8'h20;
  localparam logic [7:0] OP_LH   = 8'h21;
  localparam logic [7:0] OP_LWL  = 8'h22;
  localparam logic [7:0] OP_LW   = 8'h23;
  localparam logic [7:0] OP_LBU  = 8'h24;
  localparam logic [7:0] OP_LHU  = 8'h25;

  logic         clock = 1'b0;
  logic         reset;
  logic [159:0] esbus_i;
  logic         ms_allowin;
  logic         ws_allowin;
  logic [126:0] msbus_o;
  logic [32:0]  flushbus_i;
  logic         data_data_ok;
  logic [31:0]  data_rdata;
  logic [38:0]  msfwd_o;

  int vectors = 0;
  int miscompares = 0;
  logic [37:0] q[$];

  vie_mem_stage dut (
    .clock(clock),
    .reset(reset),
    .esbus_i(esbus_i),
    .ms_allowin(ms_allowin),
    .ws_allowin(ws_allowin),
    .msbus_o(msbus_o),
    .flushbus_i(flushbus_i),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .msfwd_o(msfwd_o)
  );

  always #5 clock = ~clock;

  function automatic logic [159:0] mk(
    input logic req, input logic [7:0] op, input logic [6:0] dest,
    input logic [31:0] pc, input logic [31:0] res,
    input logic [31:0] rt);
    return {1'b1, req, 32'h0, 1'b0, op, 8'h0, 6'h0, dest, pc, res, rt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] res, input logic [5:0] exc);
    q.push_back({exc, res});
  endtask

  task automatic send(input logic [159:0] rec, input bit exp_out,
                      input logic [31:0] res, input logic [5:0] exc);
    int n = 0;
    esbus_i = rec;
    if (exp_out) push(res, exc);
    #1;
    while (!ms_allowin && n < 20) begin
      step();
      n++;
    end
    chk("send_allowin", {31'b0, ms_allowin}, 32'd1);
    step();
    esbus_i = '0;
  endtask

  task automatic expect_out(input int maxc);
    int n = 0;
    logic [37:0] e;
    #1;
    while (!msbus_o[126] && n < maxc) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk("out_valid", {31'b0, msbus_o[126]}, 32'd1);
    if (q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("out_res", msbus_o[31:0], e[31:0]);
      chk("out_exc", {26'b0, msbus_o[76:71]}, {26'b0, e[37:32]});
    end
  endtask

  initial begin
    reset        = 1'b0;
    esbus_i      = '0;
    ws_allowin   = 1'b1;
    flushbus_i   = '0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    #3;
    chk("rst_allowin", {31'b0, ms_allowin}, 32'd1);
    chk("rst_valid", {31'b0, msbus_o[126]}, 32'd0);
    chk("rst_fwd", {31'b0, msfwd_o != 39'd0}, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // non-load
    send(mk(1'b0, OP_ADDU, 7'd5, 32'h400, 32'h1234, 32'h0),
         1'b1, 32'h1234, 6'h0);
    expect_out(0);
    chk("addu_we", {31'b0, msfwd_o[37]}, 32'd1);
    chk("addu_wdata", msfwd_o[31:0], 32'h1234);
    step();

    // LB with 3-cycle data latency
    send(mk(1'b1, OP_LB, 7'd5, 32'h404, 32'h1000_0003, 32'h0),
         1'b1, 32'hFFFF_FF80, 6'h0);
    #1 chk("lb_blk0", {31'b0, msfwd_o[38]}, 32'd1);
    chk("lb_nov0", {31'b0, msbus_o[126]}, 32'd0);
    step();
    chk("lb_blk1", {31'b0, msfwd_o[38]}, 32'd1);
    step();
    chk("lb_blk2", {31'b0, msfwd_o[38]}, 32'd1);
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF_FF7F;
    expect_out(0);
    chk("lb_unblk", {31'b0, msfwd_o[38]}, 32'd0);
    step();
    data_data_ok = 1'b0;

    // LBU, data in entry cycle
    send(mk(1'b1, OP_LBU, 7'd6, 32'h408, 32'h1000_0003, 32'h0),
         1'b1, 32'h0000_0080, 6'h0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF_FF7F;
    expect_out(0);
    step();
    data_data_ok = 1'b0;

    // halfword sign and zero extension
    send(mk(1'b1, OP_LH, 7'd7, 32'h40C, 32'h1000_0002, 32'h0),
         1'b1, 32'hFFFF_8001, 6'h0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h8001_7FFF;
    expect_out(0);
    step();
    data_data_ok = 1'b0;
    send(mk(1'b1, OP_LHU, 7'd7, 32'h410, 32'h1000_0000, 32'h0),
         1'b1, 32'h0000_7FFF, 6'h0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h8001_7FFF;
    expect_out(0);
    step();
    data_data_ok = 1'b0;

    // flush kills pending LW; its late response must be dropped
    send(mk(1'b1, OP_LW, 7'd8, 32'h414, 32'h2000, 32'h0),
         1'b0, 32'h0, 6'h0);
    flushbus_i[32] = 1'b1;
    #1 chk("flush_nofwd", {31'b0, msbus_o[126]}, 32'd0);
    step();
    flushbus_i = '0;
    #1 chk("flush_kill", {31'b0, msfwd_o[37]}, 32'd0);
    chk("disc_inc", {30'b0, dut.discard_cnt}, 32'd1);
    send(mk(1'b1, OP_LW, 7'd9, 32'h418, 32'h2004, 32'h0),
         1'b1, 32'h1357_2468, 6'h0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    #1 chk("disc_blk", {31'b0, msfwd_o[38]}, 32'd1);
    chk("disc_nov", {31'b0, msbus_o[126]}, 32'd0);
    step();
    data_data_ok = 1'b0;
    #1 chk("disc_dec", {30'b0, dut.discard_cnt}, 32'd0);
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'h1357_2468;
    expect_out(0);
    step();
    data_data_ok = 1'b0;

    // writeback stall holds registered load data
    ws_allowin = 1'b0;
    send(mk(1'b1, OP_LW, 7'd10, 32'h41C, 32'h2008, 32'h0),
         1'b1, 32'hCAFE_F00D, 6'h0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    #1 chk("hold_v0", {31'b0, msbus_o[126]}, 32'd1);
    chk("hold_alw", {31'b0, ms_allowin}, 32'd0);
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'hFFFF_FFFF;
    #1 chk("hold_r1", msbus_o[31:0], 32'hCAFE_F00D);
    step();
    chk("hold_r2", msbus_o[31:0], 32'hCAFE_F00D);
    chk("hold_v2", {31'b0, msbus_o[126]}, 32'd1);
    ws_allowin = 1'b1;
    expect_out(0);
    step();

    // back-to-back non-loads
    esbus_i = mk(1'b0, OP_ADDU, 7'd3, 32'h420, 32'hA, 32'h0);
    push(32'hA, 6'h0);
    step();
    esbus_i = mk(1'b0, OP_ADDU, 7'd4, 32'h424, 32'hB, 32'h0);
    push(32'hB, 6'h0);
    chk("b2b_alw", {31'b0, ms_allowin}, 32'd1);
    expect_out(0);
    step();
    esbus_i = '0;
    expect_out(0);
    step();

    // unaligned LWL
`ifdef VIE_MEM_UNALIGNED_EN
    send(mk(1'b1, OP_LWL, 7'd11, 32'h428, 32'h1001, 32'h1122_3344),
         1'b1, 32'hCCDD_3344, 6'h0);
    #1 chk("lwl_blk", {31'b0, msfwd_o[38]}, 32'd1);
    data_data_ok = 1'b1;
    data_rdata   = 32'hAABB_CCDD;
    expect_out(0);
    step();
    data_data_ok = 1'b0;
`else
    send(mk(1'b1, OP_LWL, 7'd11, 32'h428, 32'h1001, 32'h1122_3344),
         1'b1, 32'h0000_1001, 6'h1);
    expect_out(0);
    chk("lwl_disc", {30'b0, dut.discard_cnt}, 32'd1);
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'hAABB_CCDD;
    step();
    data_data_ok = 1'b0;
    #1 chk("lwl_disc0", {30'b0, dut.discard_cnt}, 32'd0);
`endif

    // async reset mid-load with data captured
    ws_allowin = 1'b0;
    send(mk(1'b1, OP_LW, 7'd12, 32'h42C, 32'h200C, 32'h0),
         1'b1, 32'h5, 6'h0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h5;
    step();
    data_data_ok = 1'b0;
    #1 chk("pre_rst_v", {31'b0, msbus_o[126]}, 32'd1);
    #1 reset = 1'b0;
    #1 chk("arst_alw", {31'b0, ms_allowin}, 32'd1);
    chk("arst_bus", {31'b0, msbus_o != 127'd0}, 32'd0);
    chk("arst_fwd", {31'b0, msfwd_o != 39'd0}, 32'd0);
    q.delete();
    step();
    reset      = 1'b1;
    ws_allowin = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
